// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: FSM state encoding and the
// default cache line width.
package rv32i_types;

    localparam int unsigned CACHE_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        GAP     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Grant selection between the I and D cache clients.
// Optional feature macro: CACHE_ARBITER_RR_EN (round-robin on simultaneous
// requests); when undefined, D always wins a tie.
module cache_arbiter_grant (
    input  logic i_req,
    input  logic d_req,
`ifdef CACHE_ARBITER_RR_EN
    input  logic last_d,
`endif
    output logic grant_valid,
    output logic grant_d
);

    // Pick the winning client; a lone requester always wins
    always_comb begin
        grant_valid = i_req | d_req;
`ifdef CACHE_ARBITER_RR_EN
        if (i_req && d_req) begin
            grant_d = ~last_d;
        end else begin
            grant_d = d_req;
        end
`else
        grant_d = d_req;
`endif
    end

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single physical memory port.
// Optional feature macro: CACHE_ARBITER_RR_EN selects round-robin tie
// breaking instead of fixed D-over-I priority.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned LINE_WIDTH = CACHE_LINE_WIDTH,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state;
    logic       grant_valid;
    logic       grant_d;
`ifdef CACHE_ARBITER_RR_EN
    logic       last_d;
`endif

    cache_arbiter_grant u_grant (
        .i_req       (i_pmem_read),
        .d_req       (d_pmem_read | d_pmem_write),
`ifdef CACHE_ARBITER_RR_EN
        .last_d      (last_d),
`endif
        .grant_valid (grant_valid),
        .grant_d     (grant_d)
    );

    // Arbitration FSM: grant from IDLE, hold until memory responds, one GAP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
`ifdef CACHE_ARBITER_RR_EN
            last_d <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state <= grant_d ? SERVE_D : SERVE_I;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state  <= GAP;
`ifdef CACHE_ARBITER_RR_EN
                        last_d <= 1'b0;
`endif
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state  <= GAP;
`ifdef CACHE_ARBITER_RR_EN
                        last_d <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is broadcast; each client only trusts it with its own resp
    always_comb begin
        i_pmem_rdata = pmem_rdata;
        d_pmem_rdata = pmem_rdata;
    end

    // Memory-side mux: pass the granted client through, everything quiet otherwise
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter. Build with CACHE_ARBITER_RR_EN
// defined to exercise round-robin tie breaking instead of fixed priority.
module tb_cache_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst_n;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int unsigned vectors;
    int unsigned miscompares;

    logic [LW-1:0] pat_a;
    logic [LW-1:0] pat_5;

    cache_arbiter #(
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}
    function automatic logic [3:0] strb();
        return {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0044;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_0088;
        d_pmem_wdata = pat_5;
        cyc();
        cyc();
        #1;
        if (strb() !== 4'b0000) begin
            $display("FAIL reset_strobes got %b want %b", strb(), 4'b0000);
            miscompares++;
        end
        vectors++;
        if (pmem_address !== 32'h0 || pmem_wdata !== '0) begin
            $display("FAIL reset_addr_wdata got addr %h wdata_nonzero %b want 0", pmem_address, |pmem_wdata);
            miscompares++;
        end
        vectors++;
        quiet();
        rst_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_i_read();
        // cycle N
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0060;
        #1;
        if (strb() !== 4'b0000) begin
            $display("FAIL iread_n got %b want %b", strb(), 4'b0000);
            miscompares++;
        end
        vectors++;
        cyc(); // N+1
        if (strb() !== 4'b1000 || pmem_address !== 32'h0000_0060) begin
            $display("FAIL iread_n1 got %b addr %h want 1000 addr 00000060", strb(), pmem_address);
            miscompares++;
        end
        vectors++;
        cyc(); // N+2
        cyc(); // N+3
        pmem_rdata = pat_a;
        pmem_resp = 1'b1;
        #1;
        if (strb() !== 4'b1010) begin
            $display("FAIL iread_resp got %b want %b", strb(), 4'b1010);
            miscompares++;
        end
        vectors++;
        if (i_pmem_rdata !== pat_a || d_pmem_rdata !== pat_a) begin
            $display("FAIL iread_rdata got %h want %h", i_pmem_rdata, pat_a);
            miscompares++;
        end
        vectors++;
        cyc(); // N+4: GAP even though request is still high
        pmem_resp = 1'b0;
        #1;
        if (strb() !== 4'b0000) begin
            $display("FAIL iread_gap got %b want %b", strb(), 4'b0000);
            miscompares++;
        end
        vectors++;
        cyc(); // N+5: IDLE
        if (strb() !== 4'b0000) begin
            $display("FAIL iread_idle got %b want %b", strb(), 4'b0000);
            miscompares++;
        end
        vectors++;
        cyc(); // N+6: still requesting, so granted again
        if (strb() !== 4'b1000) begin
            $display("FAIL iread_regrant got %b want %b", strb(), 4'b1000);
            miscompares++;
        end
        vectors++;
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
        quiet();
        cyc();
    endtask

    task automatic test_d_write();
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = pat_5;
        cyc();
        if (strb() !== 4'b0100 || pmem_address !== 32'h0000_1000 || pmem_wdata !== pat_5) begin
            $display("FAIL dwrite_grant got %b addr %h wdata %h", strb(), pmem_address, pmem_wdata);
            miscompares++;
        end
        vectors++;
        pmem_resp = 1'b1;
        #1;
        if (strb() !== 4'b0101) begin
            $display("FAIL dwrite_resp got %b want %b", strb(), 4'b0101);
            miscompares++;
        end
        vectors++;
        cyc();
        pmem_resp = 1'b0;
        #1;
        if (strb() !== 4'b0000 || pmem_wdata !== '0) begin
            $display("FAIL dwrite_gap got %b wdata_nonzero %b want 0000 0", strb(), |pmem_wdata);
            miscompares++;
        end
        vectors++;
        quiet();
        cyc();
    endtask

`ifndef CACHE_ARBITER_RR_EN
    task automatic test_simultaneous();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0100;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0200;
        cyc();
        if (strb() !== 4'b1000 || pmem_address !== 32'h0000_0200) begin
            $display("FAIL simul_d_first got %b addr %h want 1000 addr 00000200", strb(), pmem_address);
            miscompares++;
        end
        vectors++;
        pmem_resp = 1'b1;
        #1;
        if (strb() !== 4'b1001) begin
            $display("FAIL simul_d_resp got %b want %b", strb(), 4'b1001);
            miscompares++;
        end
        vectors++;
        cyc(); // GAP
        pmem_resp = 1'b0;
        d_pmem_read = 1'b0;
        cyc(); // IDLE
        cyc(); // SERVE_I
        if (strb() !== 4'b1000 || pmem_address !== 32'h0000_0100) begin
            $display("FAIL simul_i_second got %b addr %h want 1000 addr 00000100", strb(), pmem_address);
            miscompares++;
        end
        vectors++;
        pmem_resp = 1'b1;
        #1;
        if (strb() !== 4'b1010) begin
            $display("FAIL simul_i_resp got %b want %b", strb(), 4'b1010);
            miscompares++;
        end
        vectors++;
        cyc();
        quiet();
        cyc();
    endtask
`else
    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 32'h0000_0100;
        exp_addr[1] = 32'h0000_0200;
        exp_addr[2] = 32'h0000_0100;
        exp_addr[3] = 32'h0000_0200;
        // fresh reset so the last-served flag starts at D
        quiet();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0100;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0200;
        for (int r = 0; r < 4; r++) begin
            cyc(); // SERVE
            if (pmem_address !== exp_addr[r] || strb() !== 4'b1000) begin
                $display("FAIL rr_round%0d got addr %h strb %b want addr %h strb 1000", r, pmem_address, strb(), exp_addr[r]);
                miscompares++;
            end
            vectors++;
            pmem_resp = 1'b1;
            cyc(); // GAP
            pmem_resp = 1'b0;
            cyc(); // IDLE
        end
        quiet();
        cyc();
    endtask
`endif

    task automatic test_no_preempt();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0400;
        cyc(); // SERVE_I
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_0800;
        d_pmem_wdata = pat_5;
        cyc();
        cyc();
        if (strb() !== 4'b1000 || pmem_address !== 32'h0000_0400 || pmem_wdata !== '0) begin
            $display("FAIL nopreempt got %b addr %h want 1000 addr 00000400", strb(), pmem_address);
            miscompares++;
        end
        vectors++;
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b0;
        cyc(); // IDLE
        cyc(); // SERVE_D for the waiting writer
        if (strb() !== 4'b0100 || pmem_address !== 32'h0000_0800) begin
            $display("FAIL nopreempt_loser got %b addr %h want 0100 addr 00000800", strb(), pmem_address);
            miscompares++;
        end
        vectors++;
        pmem_resp = 1'b1;
        cyc();
        quiet();
        cyc();
    endtask

    task automatic test_drop_request();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0C00;
        cyc(); // SERVE_D
        d_pmem_read = 1'b0;
        cyc();
        if (strb() !== 4'b0000) begin
            $display("FAIL drop_strobes got %b want %b", strb(), 4'b0000);
            miscompares++;
        end
        vectors++;
        pmem_resp = 1'b1;
        #1;
        if (strb() !== 4'b0001) begin
            $display("FAIL drop_held_resp got %b want %b", strb(), 4'b0001);
            miscompares++;
        end
        vectors++;
        cyc();
        quiet();
        cyc();
    endtask

    task automatic test_reset_mid();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0300;
        cyc(); // SERVE_D
        if (strb() !== 4'b1000) begin
            $display("FAIL rstmid_pre got %b want %b", strb(), 4'b1000);
            miscompares++;
        end
        vectors++;
        #2;
        rst_n = 1'b0;
        #1;
        if (strb() !== 4'b0000 || pmem_address !== 32'h0) begin
            $display("FAIL rstmid_async got %b addr %h want 0000 addr 0", strb(), pmem_address);
            miscompares++;
        end
        vectors++;
        cyc();
        d_pmem_read = 1'b0;
        rst_n = 1'b1;
        cyc();
        pmem_resp = 1'b1;
        #1;
        if (strb() !== 4'b0000) begin
            $display("FAIL rstmid_late_resp got %b want %b", strb(), 4'b0000);
            miscompares++;
        end
        vectors++;
        cyc();
        pmem_resp = 1'b0;
        #1;
        if (strb() !== 4'b0000) begin
            $display("FAIL rstmid_no_resume got %b want %b", strb(), 4'b0000);
            miscompares++;
        end
        vectors++;
        quiet();
        cyc();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        pat_a = {8{32'hAAAA_AAAA}};
        pat_5 = {8{32'h5555_5555}};
        rst_n = 1'b0;
        quiet();
        test_reset();
        test_i_read();
        test_d_write();
`ifndef CACHE_ARBITER_RR_EN
        test_simultaneous();
`else
        test_back_to_back();
`endif
        test_no_preempt();
        test_drop_request();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
